// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path: FSM states,
// default reset vector / PC step, and instruction field bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP      = 4;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    // Instructions are word aligned, so the low two address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with sequential adder; a redirect load has
// priority over a sequential advance.
module fetch_pc_reg #(
    parameter logic [31:0] RESET_VECTOR = cpu_pkg::DEFAULT_RESET_VECTOR,
    parameter int unsigned PC_STEP      = cpu_pkg::DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_seq
);

    // 32-bit add wraps naturally modulo 2^32.
    assign pc_seq = pc + 32'(PC_STEP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc_seq;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, holds the
// current instruction for the control unit, and handles branch redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = cpu_pkg::DEFAULT_RESET_VECTOR,
    parameter int unsigned PC_STEP      = cpu_pkg::DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_we,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [5:0]  op_code,
    output logic [5:0]  func_code,
    output logic [15:0] imm,
    output logic        instr_valid,
    output logic [31:0] pc_out
);

    import cpu_pkg::*;

    fetch_state_e state, next_state;
    logic [31:0]  pc, pc_seq, target, fetch_addr, fa_next, ir;
    logic         pc_load, pc_adv, fa_load, ir_load, valid_set, valid_clr;
    logic         unused_ir_bits;

    assign target = word_align(branch_target);

    fetch_pc_reg #(
        .RESET_VECTOR (RESET_VECTOR),
        .PC_STEP      (PC_STEP)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .target  (target),
        .advance (pc_adv),
        .pc      (pc),
        .pc_seq  (pc_seq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  next_state = FETCH;
            FETCH: begin
                if (branch_taken && !imem_ack)      next_state = DROP;
                else if (!branch_taken && imem_ack) next_state = ISSUE;
            end
            DROP:  if (imem_ack) next_state = FETCH;
            ISSUE: if (branch_taken || pc_we) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        pc_load   = 1'b0;
        pc_adv    = 1'b0;
        fa_load   = 1'b0;
        fa_next   = pc;
        ir_load   = 1'b0;
        valid_set = 1'b0;
        valid_clr = 1'b0;
        unique case (state)
            IDLE: fa_load = 1'b1;
            FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_load = 1'b1;
                    fa_load = imem_ack;
                    fa_next = target;
                end else if (imem_ack) begin
                    ir_load   = 1'b1;
                    valid_set = 1'b1;
                end
            end
            DROP: begin
                // A redirect landing with the ack must refetch from the new target.
                imem_req = 1'b1;
                pc_load  = branch_taken;
                fa_load  = imem_ack;
                fa_next  = branch_taken ? target : pc;
            end
            ISSUE: begin
                if (branch_taken) begin
                    pc_load   = 1'b1;
                    valid_clr = 1'b1;
                    fa_load   = 1'b1;
                    fa_next   = target;
                end else if (pc_we) begin
                    pc_adv    = 1'b1;
                    valid_clr = 1'b1;
                    fa_load   = 1'b1;
                    fa_next   = pc_seq;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr  <= RESET_VECTOR;
            ir          <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (fa_load)   fetch_addr  <= fa_next;
            if (ir_load)   ir          <= imem_rdata;
            if (valid_set) instr_valid <= 1'b1;
            else if (valid_clr) instr_valid <= 1'b0;
        end
    end

    assign imem_addr = fetch_addr;
    assign pc_out    = pc;
    assign op_code   = instr_valid ? ir[OP_MSB:OP_LSB]     : '0;
    assign func_code = instr_valid ? ir[FUNC_MSB:FUNC_LSB] : '0;
    assign imm       = instr_valid ? ir[IMM_MSB:IMM_LSB]   : '0;

    assign unused_ir_bits = ^ir[OP_LSB-1:IMM_MSB+1];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized memory latency, branches and stalls against a behavioural model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        pc_we = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, pc_out;
    logic [5:0]  op_code, func_code;
    logic [15:0] imm;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc;
    logic [5:0]  w_op, w_func;
    logic [15:0] w_imm;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_we(pc_we),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .op_code(op_code), .func_code(func_code), .imm(imm),
        .instr_valid(instr_valid), .pc_out(pc_out)
    );

    // Second instance starting at the top of the address space; its control
    // flow matches the first instance, only the addresses differ.
    instr_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_we(pc_we),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .op_code(w_op), .func_code(w_func), .imm(w_imm),
        .instr_valid(w_valid), .pc_out(w_pc)
    );

    typedef enum {M_BOOT, M_WAIT, M_HOLD, M_DISCARD} mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc, m_addr, m_ir;
    logic        m_valid;
    int          checks = 0;
    int          errors = 0;
    int          mem_cnt = 0;
    int          mem_lat = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = M_BOOT;
        m_pc    = 32'h0;
        m_addr  = 32'h0;
        m_ir    = 32'h0;
        m_valid = 1'b0;
    endfunction

    // Behaviour of one clock edge, written from the fetch rules.
    function automatic void model_step(input logic ack, input logic [31:0] rd,
                                       input logic br, input logic [31:0] tg,
                                       input logic we);
        logic [31:0] t;
        t = {tg[31:2], 2'b00};
        case (m_mode)
            M_BOOT: begin
                m_addr = m_pc;
                m_mode = M_WAIT;
            end
            M_WAIT: begin
                if (br) begin
                    m_pc = t;
                    if (ack) m_addr = t;
                    else     m_mode = M_DISCARD;
                end else if (ack) begin
                    m_ir    = rd;
                    m_valid = 1'b1;
                    m_mode  = M_HOLD;
                end
            end
            M_DISCARD: begin
                if (br) m_pc = t;
                if (ack) begin
                    m_addr = m_pc;
                    m_mode = M_WAIT;
                end
            end
            M_HOLD: begin
                if (br || we) begin
                    m_pc    = br ? t : m_pc + 32'd4;
                    m_addr  = m_pc;
                    m_valid = 1'b0;
                    m_mode  = M_WAIT;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic compare_all();
        logic exp_req;
        exp_req = (m_mode == M_WAIT) || (m_mode == M_DISCARD);
        check("imem_req",    32'(imem_req),    32'(exp_req));
        check("imem_addr",   imem_addr,        m_addr);
        check("pc_out",      pc_out,           m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("op_code",     32'(op_code),     m_valid ? 32'(m_ir >> 26)     : 32'h0);
        check("func_code",   32'(func_code),   m_valid ? (m_ir & 32'h3F)     : 32'h0);
        check("imm",         32'(imm),         m_valid ? (m_ir & 32'hFFFF)   : 32'h0);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge happen, compare.
    task automatic step(input logic ack, input logic [31:0] rd, input logic br,
                        input logic [31:0] tg, input logic we);
        imem_ack      = ack;
        imem_rdata    = rd;
        branch_taken  = br;
        branch_target = tg;
        pc_we         = we;
        @(posedge clk);
        model_step(ack, rd, br, tg, we);
        @(negedge clk);
        compare_all();
    endtask

    // Memory answers each request after 0..3 cycles; occasional stray acks
    // arrive while no request is outstanding.
    task automatic mem_step(input logic br, input logic [31:0] tg, input logic we);
        logic ack;
        ack = 1'b0;
        if ((m_mode == M_WAIT) || (m_mode == M_DISCARD)) begin
            if (mem_cnt >= mem_lat) begin
                ack     = 1'b1;
                mem_cnt = 0;
                mem_lat = int'($urandom_range(3, 0));
            end else begin
                mem_cnt++;
            end
        end else begin
            ack     = ($urandom_range(7, 0) == 0);
            mem_cnt = 0;
        end
        step(ack, $urandom, br, tg, we);
    endtask

    task automatic apply_reset();
        #2;
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        pc_we        = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_cnt = 0;
        mem_lat = int'($urandom_range(3, 0));
        compare_all();
    endtask

    initial begin
        @(negedge clk);
        apply_reset();
        check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);

        // Sequential fetch, ack two cycles after the request.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0020, 1'b0, 32'h0, 1'b0);
        check("first_func", 32'(func_code), 32'h20);

        // Stall in ISSUE; stray acks with garbage must not disturb anything.
        repeat (5) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("seq_addr", imem_addr, 32'h4);
        check("wrap_second_addr", w_addr, 32'h0);

        // Redirect from ISSUE, then redirect in FETCH with a late ack.
        step(1'b1, 32'hFC00_0123, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b1);
        check("issue_branch_addr", imem_addr, 32'h100);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("drop_hold_addr", imem_addr, 32'h100);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        check("drop_refetch_addr", imem_addr, 32'h200);

        // Branch and ack in the same FETCH cycle.
        step(1'b1, 32'hCAFE_F00D, 1'b1, 32'h0000_0302, 1'b0);
        check("br_ack_addr", imem_addr, 32'h300);
        step(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);

        // Wrap of the PC at the top of the address space.
        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'h8765_4321, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("wrap_branch_addr", imem_addr, 32'h0);

        // Reset while a request is outstanding, then a stray ack before FETCH.
        check("req_before_reset", 32'(imem_req), 32'h1);
        apply_reset();
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        check("stray_ack_valid", 32'(instr_valid), 32'h0);

        repeat (3000) begin
            if ($urandom_range(499, 0) == 0) begin
                apply_reset();
            end else begin
                mem_step($urandom_range(7, 0) == 0, $urandom, 1'($urandom_range(1, 0)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
